// File: rtl/fp_div_issuer.sv
// fp_div_issuer: credit-based initiator front end for the FP divider.
// Optional oErr output enabled by defining FP_DIV_ISSUER_ERRCHK_EN.
//
// Ports:
//   clk, resetn (sync, active-high: 1 = reset)
//   iReqValid/oReqReady/iReqA/iReqB/iReqMask : request handshake
//   iFlush                                   : discard pending work
//   oDivValid/oDivA/oDivB/oDivMask           : to divider iValid/iA/iB/iMask
//   iDivDone/iDivZ                           : from divider oDone/oZ
//   oRspValid/iRspReady/oRspZ/oRspTag        : response handshake
//   oBusy                                    : work outstanding/buffered/draining
//   oErr (optional)                          : sticky protocol error
module fp_div_issuer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iReqValid,
    output logic             oReqReady,
    input  logic [31:0]      iReqA,
    input  logic [31:0]      iReqB,
    input  logic [3:0]       iReqMask,
    input  logic             iFlush,
    output logic             oDivValid,
    output logic [31:0]      oDivA,
    output logic [31:0]      oDivB,
    output logic [3:0]       oDivMask,
    input  logic             iDivDone,
    input  logic [31:0]      iDivZ,
    output logic             oRspValid,
    input  logic             iRspReady,
    output logic [31:0]      oRspZ,
    output logic [TAG_W-1:0] oRspTag,
    output logic             oBusy
`ifdef FP_DIV_ISSUER_ERRCHK_EN
    ,
    output logic             oErr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
    localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [TAG_W-1:0] itag_q, itag_d;
    logic [TAG_W-1:0] rtag;
    logic             busy_q, busy_d;

    logic             div_v_q;
    logic [31:0]      div_a_q, div_b_q;
    logic [3:0]       div_m_q;

    logic [31:0]      mem_z_q [DEPTH];
    logic [TAG_W-1:0] mem_t_q [DEPTH];

    logic             accept, done_ok, flush_go;
    logic             push, pop, full, rsp_v;
    logic [CW:0]      credit;

    assign credit    = {1'b0, out_q} + {1'b0, cnt_q};
    assign oReqReady = (state_q == RUN) && (credit < DEPTH_W);

    assign rsp_v    = (cnt_q != '0);
    assign full     = (cnt_q == DEPTH_C);
    assign accept   = iReqValid && oReqReady;
    assign done_ok  = iDivDone && (out_q != '0);
    assign flush_go = (state_q == RUN) && iFlush;
    assign push     = done_ok && (state_q == RUN) && !flush_go && !full;
    assign pop      = rsp_v && iRspReady;

    // Results return in order, so the retiring op was accepted
    // out_q accepts before the next issue tag.
    assign rtag = itag_q - TAG_W'(out_q);

    always_comb begin
        out_d = out_q;
        if (accept && !done_ok)
            out_d = out_q + CW'(1);
        else if (!accept && done_ok)
            out_d = out_q - CW'(1);

        itag_d = itag_q;
        if (accept)
            itag_d = itag_q + TAG_W'(1);

        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_go) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push)
                wr_d = wr_q + AW'(1);
            if (pop)
                rd_d = rd_q + AW'(1);
            if (push && !pop)
                cnt_d = cnt_q + CW'(1);
            else if (!push && pop)
                cnt_d = cnt_q - CW'(1);
        end

        state_d = state_q;
        unique case (state_q)
            RUN:     if (iFlush) state_d = DRAIN;
            DRAIN:   if (out_d == '0) state_d = RUN;
            default: state_d = RUN;
        endcase

        busy_d = (out_d != '0) || (cnt_d != '0) || (state_d == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= RUN;
            out_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            itag_q  <= '0;
            busy_q  <= 1'b0;
            div_v_q <= 1'b0;
            div_a_q <= '0;
            div_b_q <= '0;
            div_m_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            itag_q  <= itag_d;
            busy_q  <= busy_d;
            div_v_q <= accept;
            div_a_q <= accept ? iReqA : '0;
            div_b_q <= accept ? iReqB : '0;
            div_m_q <= accept ? iReqMask : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_z_q[wr_q] <= iDivZ;
            mem_t_q[wr_q] <= rtag;
        end
    end

    assign oDivValid = div_v_q;
    assign oDivA     = div_a_q;
    assign oDivB     = div_b_q;
    assign oDivMask  = div_m_q;
    assign oRspValid = rsp_v;
    assign oRspZ     = rsp_v ? mem_z_q[rd_q] : '0;
    assign oRspTag   = rsp_v ? mem_t_q[rd_q] : '0;
    assign oBusy     = busy_q;

`ifdef FP_DIV_ISSUER_ERRCHK_EN
    logic err_q, err_d;

    // Stray completion, or a push that would overrun a full FIFO.
    assign err_d = err_q
                 | (iDivDone && (out_q == '0))
                 | (done_ok && (state_q == RUN) && !flush_go && full);

    always_ff @(posedge clk) begin
        if (resetn)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign oErr = err_q;
`endif

endmodule

// File: doc/fp_div_issuer.md
Name: fp_div_issuer

Overview:
- Initiator-side front end for the floating-point divider.
- Accepts operand pairs over a valid/ready request port and issues them to the divider's iValid/iA/iB/iMask inputs.
- Collects the in-order oDone/oZ results into a result FIFO, tags them, and returns them over a valid/ready response port.
- Credit-based: never issues more operations than the FIFO can absorb, so divider results are never dropped.

Parameters:
- DEPTH, 8: result FIFO entries; also the maximum number of ops in flight plus buffered. Power of two, at least 2.
- TAG_W, 4: width of the sequence tag attached to each op.

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  synchronous, active-high reset; 1 = reset
- iReqValid  in  1  request valid
- oReqReady  out  1  request accepted when iReqValid && oReqReady
- iReqA  in  32  dividend, IEEE-754 single
- iReqB  in  32  divisor, IEEE-754 single
- iReqMask  in  4  mask, passed to divider unchanged
- iFlush  in  1  discard all pending work
- oDivValid  out  1  to divider iValid
- oDivA  out  32  to divider iA
- oDivB  out  32  to divider iB
- oDivMask  out  4  to divider iMask
- iDivDone  in  1  from divider oDone
- iDivZ  in  32  from divider oZ
- oRspValid  out  1  response valid
- iRspReady  in  1  response consumed when oRspValid && iRspReady
- oRspZ  out  32  quotient
- oRspTag  out  TAG_W  tag of the request that produced oRspZ
- oBusy  out  1  work outstanding, buffered, or draining

Behaviour:
- Reset values: oDivValid=0, oDivA/oDivB/oDivMask=0, oRspValid=0, oRspZ=0, oRspTag=0, oBusy=0. All counters 0, FIFO empty, state RUN. oReqReady=1 in the cycle after reset deasserts.
- Reset asserted mid-operation discards all state. Any iDivDone arriving while outstanding==0 is dropped and no counter changes.
- State machine: RUN, DRAIN.
  - RUN -> DRAIN when iFlush=1.
  - DRAIN -> RUN when outstanding==0 in that cycle (counted after that cycle's iDivDone).
  - iFlush is ignored while in DRAIN.
- oReqReady = (state==RUN) && (outstanding + fifo_count < DEPTH). Decoded from registers only; never depends on iReqValid.
- Issue: an accept in cycle N gives oDivValid=1 in cycle N+1, with oDivA/oDivB/oDivMask registered from the request.
  - Back-to-back accepts give consecutive oDivValid pulses.
  - In non-issue cycles, oDivValid=0 and oDivA/oDivB/oDivMask are driven to 0.
- outstanding counter:
  - +1 on accept, -1 on iDivDone (outstanding>0), unchanged when both occur in the same cycle.
  - Counts from accept, so it covers the issue register stage.
- Tags:
  - issue_tag increments on each accept, modulo 2^TAG_W.
  - retire_tag increments on each counted iDivDone, modulo 2^TAG_W.
  - The divider returns results in order; retire_tag is stored with iDivZ.
- FIFO:
  - Push on iDivDone in RUN; pop on oRspValid && iRspReady.
  - Registered output: iDivDone in cycle N gives oRspValid in cycle N+1 when the FIFO was empty.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Overflow cannot occur under the credit rule.
  - Full with DEPTH entries and iRspReady=0 holds oRspValid/oRspZ/oRspTag stable, with oReqReady=0.
- Flush:
  - On the RUN->DRAIN edge the FIFO is cleared, and oRspValid drops the next cycle.
  - A request presented in the flush cycle is still accepted if oReqReady=1, and is drained.
  - In DRAIN, iDivDone results are discarded while still decrementing outstanding and advancing retire_tag.
  - issue_tag and retire_tag are not reset by flush, so they stay aligned.
- oBusy = (outstanding!=0) || (fifo_count!=0) || (state==DRAIN), registered.

Optional Feature:
- Macro: FP_DIV_ISSUER_ERRCHK_EN.
- Defined:
  - Adds output oErr (1 bit, reset 0).
  - oErr is sticky and is set the cycle after iDivDone=1 arrives with outstanding==0, or after a push is attempted into a full FIFO.
  - Cleared only by resetn.
- Not defined: no oErr port; such events are silently dropped.

Test Plan:
- Single op: request A=0x3FC00000, B=0x3F000000, mask=0; divider model returns 0x40400000 after L cycles -> oDivValid pulse one cycle after accept; oRspValid with oRspZ=0x40400000 and oRspTag=0 one cycle after iDivDone; oBusy returns to 0.
- Mask passthrough: same operands with iReqMask=4'b0101 -> oDivMask=4'b0101 only in the oDivValid cycle, 0 otherwise.
- Backpressure: hold iRspReady=0 and stream 12 requests, DEPTH=8 -> exactly 8 accepted, oReqReady=0 afterwards; release iRspReady -> tags 0..7 returned in order, remaining 4 then accepted with tags 8..11.
- Tag wrap: 20 sequential ops with TAG_W=4 -> oRspTag sequence 0..15, 0..3.
- Flush: issue 3 ops, assert iFlush before any iDivDone -> oReqReady=0 until the 3rd iDivDone; no oRspValid; the next op returns tag 3.
- Reset mid-op: 2 ops in flight, pulse resetn, divider then returns 2 results -> no oRspValid; oErr=1 only when FP_DIV_ISSUER_ERRCHK_EN is defined.
